// File: rtl/qspi_psram_responder_if.sv
// rtl/qspi_psram_responder_if.sv - QSPI pin bundle plus byte-wide memory port of the PSRAM responder
// The master side is the harness (QSPI initiator pins and RAM); the slave side is the responder.
interface qspi_psram_responder_if #(
  parameter int ADDR_BITS = 24
);
  logic                 qspi_clk;
  logic                 qspi_cs_n;
  logic [3:0]           qspi_data_in;
  logic [3:0]           qspi_data_out;
  logic [3:0]           qspi_data_oe;
  logic [ADDR_BITS-1:0] mem_addr;
  logic                 mem_rd;
  logic [7:0]           mem_rdata;
  logic                 mem_wr;
  logic [7:0]           mem_wdata;
  logic                 cmd_error;

  modport master (
    output qspi_clk, qspi_cs_n, qspi_data_in, mem_rdata,
    input  qspi_data_out, qspi_data_oe, mem_addr, mem_rd, mem_wr, mem_wdata, cmd_error
  );

  modport slave (
    input  qspi_clk, qspi_cs_n, qspi_data_in, mem_rdata,
    output qspi_data_out, qspi_data_oe, mem_addr, mem_rd, mem_wr, mem_wdata, cmd_error
  );
endinterface

// File: rtl/qspi_psram_responder.sv
// rtl/qspi_psram_responder.sv - oversampling QSPI responder decoding quad write (0x02) and fast read (0xEB)
// Pins are synchronised to clk; transactions become single-clk strobes on a byte RAM port.
module qspi_psram_responder #(
  parameter int ADDR_BITS     = 24,
  parameter int DUMMY_NIBBLES = 6
) (
  input  logic                        clk,
  input  logic                        rst_n,
  qspi_psram_responder_if.slave       bus
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_ADDR   = 3'd2;
  localparam logic [2:0] S_WDATA  = 3'd3;
  localparam logic [2:0] S_DUMMY  = 3'd4;
  localparam logic [2:0] S_RDATA  = 3'd5;
  localparam logic [2:0] S_IGNORE = 3'd6;
  localparam logic [3:0] DUMMY_CNT = 4'(DUMMY_NIBBLES);

  // qclk_q: [0],[1] synchroniser, [2] previous synced value for edge detection
  logic [2:0]           qclk_q, qclk_d;
  logic [1:0]           cs_q, cs_d;
  logic [3:0]           din1_q, din1_d, din2_q, din2_d;
  logic [2:0]           state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [19:0]          sr_q, sr_d;
  logic                 is_read_q, is_read_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [7:0]           rbuf_q, rbuf_d;
  logic [7:0]           pref_q, pref_d;
  logic [3:0]           wnib_q, wnib_d;
  logic                 phase_q, phase_d;
  logic                 rd_dly_q, rd_dly_d;
  logic                 mem_rd_q, mem_rd_d;
  logic                 mem_wr_q, mem_wr_d;
  logic [7:0]           wdata_q, wdata_d;
  logic                 cmd_err_q, cmd_err_d;
  logic [3:0]           out_q, out_d;
  logic [3:0]           oe_q, oe_d;

  logic                 rise, fall, cs_hi;
  logic [3:0]           nib;
  logic [23:0]          addr_full;

  assign rise      = qclk_q[1] & ~qclk_q[2];
  assign fall      = ~qclk_q[1] & qclk_q[2];
  assign cs_hi     = cs_q[1];
  assign nib       = din2_q;
  assign addr_full = {sr_q, nib};

  always_comb begin
    qclk_d    = {qclk_q[1:0], bus.qspi_clk};
    cs_d      = {cs_q[0], bus.qspi_cs_n};
    din1_d    = bus.qspi_data_in;
    din2_d    = din1_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    is_read_d = is_read_q;
    addr_d    = addr_q;
    rbuf_d    = rbuf_q;
    pref_d    = pref_q;
    wnib_d    = wnib_q;
    phase_d   = phase_q;
    rd_dly_d  = mem_rd_q;
    mem_rd_d  = 1'b0;
    mem_wr_d  = 1'b0;
    wdata_d   = wdata_q;
    cmd_err_d = 1'b0;
    out_d     = out_q;
    oe_d      = oe_q;

    if (cs_hi) begin
      state_d  = S_IDLE;
      oe_d     = 4'h0;
      cnt_d    = 4'd0;
      phase_d  = 1'b0;
      rd_dly_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_CMD;
          cnt_d   = 4'd0;
        end
        S_CMD: if (rise) begin
          sr_d  = {sr_q[15:0], nib};
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd1) begin
            cnt_d = 4'd0;
            case ({sr_q[3:0], nib})
              8'h02: begin state_d = S_ADDR; is_read_d = 1'b0; end
              8'hEB: begin state_d = S_ADDR; is_read_d = 1'b1; end
              default: begin state_d = S_IGNORE; cmd_err_d = 1'b1; end
            endcase
          end
        end
        S_ADDR: if (rise) begin
          sr_d  = {sr_q[15:0], nib};
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd5) begin
            cnt_d  = 4'd0;
            addr_d = addr_full[ADDR_BITS-1:0];
            if (is_read_q) begin
              state_d  = S_DUMMY;
              mem_rd_d = 1'b1;
            end else begin
              state_d  = S_WDATA;
            end
          end
        end
        S_DUMMY: begin
          if (rd_dly_q) rbuf_d = bus.mem_rdata;
          if (rise && cnt_q != DUMMY_CNT) begin
            cnt_d = cnt_q + 4'd1;
          end else if (fall && cnt_q == DUMMY_CNT) begin
            state_d  = S_RDATA;
            oe_d     = 4'hF;
            out_d    = rbuf_q[7:4];
            phase_d  = 1'b1;
            addr_d   = addr_q + ADDR_BITS'(1);
            mem_rd_d = 1'b1;
          end
        end
        S_RDATA: begin
          // phase_q high means the high nibble of rbuf is on the pins now
          if (rd_dly_q) pref_d = bus.mem_rdata;
          if (fall) begin
            if (phase_q) begin
              out_d   = rbuf_q[3:0];
              phase_d = 1'b0;
            end else begin
              out_d    = pref_q[7:4];
              rbuf_d   = pref_q;
              phase_d  = 1'b1;
              addr_d   = addr_q + ADDR_BITS'(1);
              mem_rd_d = 1'b1;
            end
          end
        end
        S_WDATA: begin
          if (mem_wr_q) addr_d = addr_q + ADDR_BITS'(1);
          if (rise) begin
            if (cnt_q == 4'd0) begin
              wnib_d = nib;
              cnt_d  = 4'd1;
            end else begin
              cnt_d    = 4'd0;
              mem_wr_d = 1'b1;
              wdata_d  = {wnib_q, nib};
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qclk_q    <= 3'b000;
      cs_q      <= 2'b11;
      din1_q    <= 4'h0;
      din2_q    <= 4'h0;
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      sr_q      <= 20'h0;
      is_read_q <= 1'b0;
      addr_q    <= '0;
      rbuf_q    <= 8'h00;
      pref_q    <= 8'h00;
      wnib_q    <= 4'h0;
      phase_q   <= 1'b0;
      rd_dly_q  <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      wdata_q   <= 8'h00;
      cmd_err_q <= 1'b0;
      out_q     <= 4'h0;
      oe_q      <= 4'h0;
    end else begin
      qclk_q    <= qclk_d;
      cs_q      <= cs_d;
      din1_q    <= din1_d;
      din2_q    <= din2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      is_read_q <= is_read_d;
      addr_q    <= addr_d;
      rbuf_q    <= rbuf_d;
      pref_q    <= pref_d;
      wnib_q    <= wnib_d;
      phase_q   <= phase_d;
      rd_dly_q  <= rd_dly_d;
      mem_rd_q  <= mem_rd_d;
      mem_wr_q  <= mem_wr_d;
      wdata_q   <= wdata_d;
      cmd_err_q <= cmd_err_d;
      out_q     <= out_d;
      oe_q      <= oe_d;
    end
  end

  assign bus.qspi_data_out = out_q;
  assign bus.qspi_data_oe  = oe_q;
  assign bus.mem_addr      = addr_q;
  assign bus.mem_rd        = mem_rd_q;
  assign bus.mem_wr        = mem_wr_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.cmd_error     = cmd_err_q;
endmodule

// File: tb/tb_qspi_psram_responder.sv
// tb/tb_qspi_psram_responder.sv - directed bench for qspi_psram_responder with a 16-bit address window
module tb_qspi_psram_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  qspi_psram_responder_if #(.ADDR_BITS(16)) bus ();

  qspi_psram_responder #(.ADDR_BITS(16), .DUMMY_NIBBLES(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0]  mem [0:65535];
  logic [15:0] rd_log[$];
  logic [23:0] wr_log[$];
  int          err_pulses;
  int          both_cnt;
  int          n_checks = 0;
  int          n_errors = 0;

  always @(posedge clk) begin
    if (bus.mem_rd) begin
      bus.mem_rdata <= mem[bus.mem_addr];
      rd_log.push_back(bus.mem_addr);
    end
    if (bus.mem_wr) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
      wr_log.push_back({bus.mem_addr, bus.mem_wdata});
    end
    if (bus.cmd_error) err_pulses <= err_pulses + 1;
    if (bus.mem_rd && bus.mem_wr) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    rd_log.delete();
    wr_log.delete();
    err_pulses = 0;
  endtask

  // One qspi_clk period: falling edge with new data, then sample pins just before the rising edge
  task automatic tick(input logic [3:0] din, output logic [3:0] dout, output logic [3:0] oe);
    @(negedge clk);
    bus.qspi_clk     = 1'b0;
    bus.qspi_data_in = din;
    repeat (5) @(negedge clk);
    dout = bus.qspi_data_out;
    oe   = bus.qspi_data_oe;
    bus.qspi_clk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [3:0] d, o;
    tick(b[7:4], d, o);
    tick(b[3:0], d, o);
  endtask

  task automatic start_tx();
    @(negedge clk);
    bus.qspi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic end_tx();
    @(negedge clk);
    bus.qspi_clk = 1'b0;
    repeat (5) @(negedge clk);
    bus.qspi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic read_start(input logic [23:0] a, output logic [3:0] dummy_oe);
    logic [3:0] d, o;
    dummy_oe = 4'h0;
    start_tx();
    send_byte(8'hEB);
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    for (int i = 0; i < 6; i++) begin
      tick(4'h0, d, o);
      dummy_oe = dummy_oe | o;
    end
  endtask

  task automatic read_check(input string tag, input logic [23:0] a, input logic [15:0] exp);
    logic [3:0]  d, o, doe;
    logic [15:0] got;
    logic [3:0]  oe_and;
    read_start(a, doe);
    check({tag, "_dummy_oe"}, 32'(doe), 32'h0);
    oe_and = 4'hF;
    for (int i = 0; i < 4; i++) begin
      tick(4'h0, d, o);
      got = {got[11:0], d};
      oe_and = oe_and & o;
    end
    end_tx();
    check({tag, "_data_oe"}, 32'(oe_and), 32'hF);
    check({tag, "_nibbles"}, 32'(got), 32'(exp));
  endtask

  task automatic write_tx(input logic [23:0] a, input logic [7:0] b0, input logic [7:0] b1, input int nbytes);
    start_tx();
    send_byte(8'h02);
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    send_byte(b0);
    if (nbytes > 1) send_byte(b1);
    end_tx();
  endtask

  initial begin
    logic [3:0] d, o, doe, oe_or;
    both_cnt = 0;
    clear_logs();
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    bus.qspi_clk     = 1'b0;
    bus.qspi_cs_n    = 1'b1;
    bus.qspi_data_in = 4'h0;
    bus.mem_rdata    = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_outputs", {1'b0, bus.qspi_data_out, bus.qspi_data_oe, bus.mem_addr, bus.mem_rd,
                            bus.mem_wr, bus.mem_wdata, bus.cmd_error}, 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Quad write, upper address byte must be discarded by the 16-bit window
    clear_logs();
    write_tx(24'hAB0010, 8'hA5, 8'h3C, 2);
    check("wr_count", wr_log.size(), 2);
    check("wr0", 32'(wr_log[0]), 32'h0010A5);
    check("wr1", 32'(wr_log[1]), 32'h00113C);
    check("wr_no_rd", rd_log.size(), 0);
    check("wr_no_err", err_pulses, 0);

    // Fast read of the bytes just written
    clear_logs();
    read_check("rd", 24'h000010, 16'hA53C);
    check("rd_addr0", 32'(rd_log[0]), 32'h0010);
    check("rd_addr1", 32'(rd_log[1]), 32'h0011);
    check("rd_no_wr", wr_log.size(), 0);

    // Unsupported command followed by 8 clocks
    clear_logs();
    start_tx();
    send_byte(8'h9F);
    oe_or = 4'h0;
    for (int i = 0; i < 8; i++) begin
      tick(4'(i + 1), d, o);
      oe_or = oe_or | o;
    end
    end_tx();
    check("bad_err_pulses", err_pulses, 1);
    check("bad_no_rd", rd_log.size(), 0);
    check("bad_no_wr", wr_log.size(), 0);
    check("bad_oe", 32'(oe_or), 32'h0);
    clear_logs();
    read_check("after_bad", 24'h000010, 16'hA53C);

    // Write aborted after a single data nibble, then a clean single-byte write
    clear_logs();
    start_tx();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h20);
    tick(4'h7, d, o);
    end_tx();
    check("abort_no_wr", wr_log.size(), 0);
    write_tx(24'h000020, 8'h11, 8'h00, 1);
    check("abort_next_count", wr_log.size(), 1);
    check("abort_next_wr", 32'(wr_log[0]), 32'h002011);

    // Address wrap at the top of the 16-bit window
    mem[16'hFFFF] = 8'h12;
    mem[16'h0000] = 8'h34;
    clear_logs();
    read_check("wrap", 24'h00FFFF, 16'h1234);
    check("wrap_addr0", 32'(rd_log[0]), 32'hFFFF);
    check("wrap_addr1", 32'(rd_log[1]), 32'h0000);

    // Reset asserted while read data is on the pins
    read_start(24'h000010, doe);
    tick(4'h0, d, o);
    check("mid_first_nib", 32'(d), 32'hA);
    tick(4'h0, d, o);
    @(negedge clk);
    check("mid_oe_before", 32'(bus.qspi_data_oe), 32'hF);
    #1 rst_n = 1'b0;
    #1;
    check("mid_oe_async", 32'(bus.qspi_data_oe), 32'h0);
    check("mid_outputs", {1'b0, bus.qspi_data_out, bus.mem_addr, bus.mem_rd, bus.mem_wr,
                          bus.mem_wdata, bus.cmd_error}, 32'h0);
    bus.qspi_clk  = 1'b0;
    bus.qspi_cs_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    clear_logs();
    read_check("post_reset", 24'h000010, 16'hA53C);

    check("rd_wr_exclusive", both_cnt, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/qspi_psram_responder.md
Name: qspi_psram_responder

Overview:
- Synthesizable QSPI target (responder) that emulates a quad PSRAM/flash device behind the tinyQV QSPI initiator.
- Intended for FPGA test harnesses and on-chip loopback, where the simulation-only PMOD model is unavailable.
- Oversamples the QSPI pins on the system clock, decodes quad write (0x02) and quad fast read (0xEB) transactions, and converts them to a simple byte-wide memory port.
- Sits between the board-level QSPI pins and a synchronous byte RAM.

Parameters:
- ADDR_BITS, 24, number of low address bits forwarded to mem_addr; upper received bits are ignored, so addresses wrap modulo 2^ADDR_BITS.
- DUMMY_NIBBLES, 6, qspi_clk cycles between the last address nibble and the first read data nibble; legal range 2..15.

Ports:
- clk  input  1  system clock; must run at least 6x qspi_clk, with each qspi_clk phase lasting at least 3 clk cycles.
- rst_n  input  1  asynchronous active-low reset.
- qspi_clk  input  1  serial clock from the initiator; idle low (mode 0).
- qspi_cs_n  input  1  chip select, active low.
- qspi_data_in  input  4  IO[3:0] from the initiator.
- qspi_data_out  output  4  IO[3:0] driven to the initiator.
- qspi_data_oe  output  4  per-bit output enable; always all-ones or all-zeros.
- mem_addr  output  ADDR_BITS  byte address for mem_rd / mem_wr.
- mem_rd  output  1  one-clk read strobe.
- mem_rdata  input  8  read data; valid exactly one clk after mem_rd.
- mem_wr  output  1  one-clk write strobe.
- mem_wdata  output  8  write data, valid while mem_wr is high.
- cmd_error  output  1  one-clk pulse when an unsupported command byte completes.

Behaviour:
- Reset:
  - All outputs are 0 and the state is IDLE.
  - Assertion takes effect immediately, including mid-transaction; qspi_data_oe drops asynchronously.
- Synchronisation:
  - qspi_clk, qspi_cs_n and qspi_data_in each pass through a 2-flop synchroniser; the data path uses the same delay as the clock path.
  - Rising edge = synced clk 0->1. Input nibbles are sampled on this edge.
  - Falling edge = synced clk 1->0. Output nibbles change on this edge.
- All fields are transferred MSB nibble first, 4 bits per qspi_clk.
- States:
  - IDLE: wait for synced cs_n low, then go to CMD with nibble count 0.
  - CMD: collect 2 nibbles.
    - 0x02 -> ADDR (write).
    - 0xEB -> ADDR (read).
    - Any other value -> pulse cmd_error, go to IGNORE.
  - ADDR: collect 6 nibbles (24 bits) and latch the low ADDR_BITS into the address register.
    - Write: go to WDATA.
    - Read: go to DUMMY and pulse mem_rd on the clk after the 6th nibble is sampled; capture mem_rdata into the byte buffer one clk later.
  - DUMMY: count DUMMY_NIBBLES rising edges; oe stays 0.
    - On the falling edge after the last dummy rising edge: set oe = 4'hF, drive buffer[7:4], go to RDATA.
  - RDATA: alternate buffer[3:0] and the next byte's [7:4] on successive falling edges.
    - After the high nibble is driven: increment the address (wrapping) and pulse mem_rd for it.
    - Capture the result into a prefetch register, which transfers to the buffer when the low nibble completes.
    - Continues indefinitely until CS rises.
  - WDATA: every second sampled nibble completes a byte.
    - mem_wr pulses for 1 clk with mem_addr = current address and mem_wdata = {first nibble, second nibble}.
    - The address increments (wrapping) on the following clk.
  - IGNORE: no memory activity, oe = 0, until CS rises.
- CS deassertion (synced cs_n high) from any state:
  - Next clk: state IDLE, oe = 0, nibble counters cleared.
  - A half-received write byte is discarded with no mem_wr.
  - An in-flight read or prefetch is dropped.
- mem_rd and mem_wr are never high in the same clk.
- Neither strobe is issued in IDLE or IGNORE.
- qspi_data_out holds its last value while oe = 0; its value there is don't-care.

Test Plan:
- Write: CS low, cmd 0x02, addr 0x000010, data 0xA5 0x3C, CS high -> exactly two mem_wr pulses: (0x10, 0xA5) then (0x11, 0x3C); cmd_error never pulses.
- Read: RAM preloaded 0x10=0xA5, 0x11=0x3C; cmd 0xEB, addr 0x000010, 6 dummy clocks, 4 data clocks -> initiator samples nibbles A, 5, 3, C; oe low through all dummy rising edges and high from the falling edge after the 6th dummy.
- Unsupported command: cmd 0x9F, then 8 further clocks -> single cmd_error pulse, no mem_rd/mem_wr, oe stays 0; a following 0xEB transaction works normally.
- Aborted write: CS high after one data nibble (0x7) -> no mem_wr; the next write to 0x20 with 0x11 writes exactly (0x20, 0x11).
- Wrap: ADDR_BITS=16, RAM 0xFFFF=0x12, 0x0000=0x34; read at 0x00FFFF for 2 bytes -> nibbles 1, 2, 3, 4; mem_rd addresses 0xFFFF then 0x0000.
- Reset mid-read: assert rst_n low during RDATA -> qspi_data_oe = 0 within the same clk and all outputs 0; after release a fresh read at 0x10 returns 0xA5.
